// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, FSM state type and round helpers.
// SHA224_MODE_EN additionally provides the SHA-224 initial hash values.
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [0:7] hash_t;
    typedef enum logic [2:0] {IDLE, READ, COMPUTE, UPDATE, WRITE} state_t;

    localparam word_t [0:63] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam hash_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`ifdef SHA224_MODE_EN
    localparam hash_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

    function automatic word_t rightrotate(word_t x, int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(word_t x);
        return rightrotate(x, 2) ^ rightrotate(x, 13) ^ rightrotate(x, 22);
    endfunction

    function automatic word_t big_sigma1(word_t x);
        return rightrotate(x, 6) ^ rightrotate(x, 11) ^ rightrotate(x, 25);
    endfunction

    function automatic word_t small_sigma0(word_t x);
        return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(word_t x);
        return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(word_t x, word_t y, word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(word_t x, word_t y, word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // s[0..7] holds the working variables a..h
    function automatic hash_t sha_round(hash_t s, word_t w, word_t k);
        word_t t1, t2;
        t1 = s[7] + big_sigma1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
        t2 = big_sigma0(s[0]) + maj(s[0], s[1], s[2]);
        return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word rolling message schedule; w0 is the current round's W[t].
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  load,
    input  logic  shift,
    input  word_t din,
    output word_t w0
);

    word_t [0:15] win_q, win_d;
    word_t nxt;

    always_comb begin
        nxt = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
        win_d = (load || shift) ? {win_q[1:15], load ? din : nxt} : win_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) win_q <= '0;
        else win_q <= win_d;

    assign w0 = win_q[0];

endmodule

// File: rtl/sha256_multiblock.sv
// sha256_multiblock: multi-block SHA-256 over a word-addressed memory with internal padding.
// SHA224_MODE_EN adds the mode224 input selecting SHA-224 IVs and a 7-word digest.
module sha256_multiblock
    import sha256_pkg::*;
#(
    parameter int MAX_WORDS = 64,
    parameter int BLK_W     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] num_words,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
`ifdef SHA224_MODE_EN
    input  logic        mode224,
`endif
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_t state_q, state_d;
    logic [6:0] cnt_q, cnt_d, last_w;
    logic [BLK_W-1:0] blk_q, blk_d, nblk_q, nblk_d;
    logic [15:0] nw_q, nw_d, maddr_q, maddr_d, oaddr_q, oaddr_d, nw_in, g;
    hash_t h_q, h_d, s_q, s_d, hsum, iv;
    logic [3:0] tw;
    logic [63:0] bitlen;
    logic start_go, lastblk;
    word_t din, w0;

`ifdef SHA224_MODE_EN
    logic m224_q, m224_d;
    assign m224_d = start_go ? mode224 : m224_q;
    assign iv = mode224 ? IV224 : IV256;
    assign last_w = m224_q ? 7'd6 : 7'd7;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) m224_q <= 1'b0;
        else m224_q <= m224_d;
`else
    assign iv = IV256;
    assign last_w = 7'd7;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q == IDLE    ? (start ? READ : IDLE) :
                  state_q == READ    ? (cnt_q == 7'd16 ? COMPUTE : READ) :
                  state_q == COMPUTE ? (cnt_q == 7'd63 ? UPDATE : COMPUTE) :
                  state_q == UPDATE  ? (blk_q + BLK_W'(1) < nblk_q ? READ : WRITE) :
                                       (cnt_q == last_w ? IDLE : WRITE);
    end

    always_comb begin
        start_go = state_q == IDLE && start;
        nw_in = num_words > 16'(MAX_WORDS) ? 16'(MAX_WORDS) : num_words;
        nw_d = start_go ? nw_in : nw_q;
        nblk_d = start_go ? BLK_W'((nw_in + 16'd2) / 16'd16 + 16'd1) : nblk_q;
        maddr_d = start_go ? message_addr : maddr_q;
        oaddr_d = start_go ? output_addr : oaddr_q;
        blk_d = start_go ? '0 : (state_q == UPDATE && state_d == READ) ? blk_q + BLK_W'(1) : blk_q;
        cnt_d = state_d != state_q ? '0 : cnt_q + 7'd1;
        for (int i = 0; i < 8; i++) hsum[i] = h_q[i] + s_q[i];
        h_d = start_go ? iv : state_q == UPDATE ? hsum : h_q;
        s_d = state_q == READ ? h_q : state_q == COMPUTE ? sha_round(s_q, w0, K[cnt_q[5:0]]) : s_q;
        // capture on READ cycles 1..16 belongs to word t = cycle-1
        tw = cnt_q[3:0] - 4'd1;
        g = 16'({blk_q, tw});
        lastblk = blk_q == nblk_q - BLK_W'(1);
        bitlen = {43'd0, nw_q, 5'd0};
        din = g < nw_q              ? mem_read_data :
              g == nw_q             ? 32'h8000_0000 :
              lastblk && tw == 4'd14 ? bitlen[63:32] :
              lastblk && tw == 4'd15 ? bitlen[31:0] : '0;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt_q   <= '0;
            blk_q   <= '0;
            nblk_q  <= '0;
            nw_q    <= '0;
            maddr_q <= '0;
            oaddr_q <= '0;
            h_q     <= '0;
            s_q     <= '0;
        end else begin
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            nblk_q  <= nblk_d;
            nw_q    <= nw_d;
            maddr_q <= maddr_d;
            oaddr_q <= oaddr_d;
            h_q     <= h_d;
            s_q     <= s_d;
        end

    sha256_msg_sched u_sched (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (state_q == READ && cnt_q != 7'd0),
        .shift  (state_q == COMPUTE),
        .din    (din),
        .w0     (w0)
    );

    always_comb begin
        done = state_q == IDLE;
        mem_we = state_q == WRITE;
        mem_addr = (state_q == READ && !cnt_q[4]) ? maddr_q + 16'({blk_q, cnt_q[3:0]}) :
                   mem_we ? oaddr_q + 16'(cnt_q) : '0;
        mem_write_data = mem_we ? h_q[cnt_q[2:0]] : '0;
    end

    assign mem_clk = clk;

endmodule

// File: tb/tb_sha256_multiblock.sv
// tb_sha256_multiblock: directed digests, latency, address wrap, clamp and mid-run reset.
module tb_sha256_multiblock;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_words = '0, message_addr = '0, output_addr = '0;
    logic        done, mem_clk, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = '0;
`ifdef SHA224_MODE_EN
    logic        mode224 = 1'b0;
`endif

    logic [31:0] mem [0:65535];
    logic        tb_wr = 1'b0;
    logic [15:0] tb_waddr = '0;
    logic [31:0] tb_wdata = '0;
    logic [31:0] msg_buf [0:127];
    int n_checks = 0, n_errs = 0, we_cnt = 0, cyc = 0, we_snap = 0;

    localparam logic [31:0] TK [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    sha256_multiblock dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .num_words     (num_words),
        .message_addr  (message_addr),
        .output_addr   (output_addr),
`ifdef SHA224_MODE_EN
        .mode224       (mode224),
`endif
        .done          (done),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge mem_clk) begin
        if (tb_wr) mem[tb_waddr] <= tb_wdata;
        else if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [31:0] d);
        tb_wr = 1'b1; tb_waddr = a; tb_wdata = d;
        @(posedge clk); #1;
        tb_wr = 1'b0;
    endtask

    task automatic load_msg(input logic [15:0] ma, input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            msg_buf[i] = (32'h9e3779b9 * 32'(i + seed)) ^ 32'h5a5a_0f0f ^ 32'(i << 20);
            put(ma + 16'(i), msg_buf[i]);
        end
    endtask

    // start is high for exactly one sampled edge; cyc counts edges until done is seen
    task automatic run(input logic [15:0] ma, input logic [15:0] oa, input logic [15:0] n);
        message_addr = ma; output_addr = oa; num_words = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_digest(input string tag, input logic [15:0] oa, input logic [255:0] exp, input int nw);
        for (int k = 0; k < nw; k++)
            check($sformatf("%s_h%0d", tag, k), mem[oa + 16'(k)], exp[255 - 32*k -: 32]);
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_sha(input int n);
        logic [31:0] h [0:7];
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, gg, hh, t1, t2;
        int nb, idx;
        h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        nb = (n + 18) / 16;
        for (int bk = 0; bk < nb; bk++) begin
            for (int t = 0; t < 64; t++) begin
                idx = bk * 16 + t;
                if (t >= 16)
                    w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                         + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
                else
                    w[t] = idx < n ? msg_buf[idx] : idx == n ? 32'h8000_0000 :
                           (bk == nb - 1 && t == 15) ? 32'(n * 32) : 32'h0;
            end
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; gg = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & gg)) + TK[t] + w[t];
                t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = gg; gg = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += gg; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_done", 32'(done), 32'd1);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);

        put(16'h0208, 32'hdead_beef);
        run(16'h0100, 16'h0200, 16'd0);
        check("n0_lat", 32'(cyc), 32'd91);
        check_digest("n0", 16'h0200, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 8);
        check("n0_w8", mem[16'h0208], 32'hdead_beef);

        put(16'h0300, 32'h6162_6364);
        run(16'h0300, 16'h0210, 16'd1);
        check("abcd_lat", 32'(cyc), 32'd91);
        check_digest("abcd", 16'h0210, 256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589, 8);

        load_msg(16'h0400, 14, 7);
        run(16'h0400, 16'h0220, 16'd13);
        check("n13_lat", 32'(cyc), 32'd91);
        check_digest("n13", 16'h0220, ref_sha(13), 8);
        run(16'h0400, 16'h0230, 16'd14);
        check("n14_lat", 32'(cyc), 32'd173);
        check_digest("n14", 16'h0230, ref_sha(14), 8);

        for (int i = 0; i < 8; i++) put(16'h0260 + 16'(i), 32'hcafe_0000 + 32'(i));
        message_addr = 16'h0400; output_addr = 16'h0260; num_words = 16'd14; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (120) @(posedge clk);
        #1 reset_n = 1'b0;
        we_snap = we_cnt;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("rstmid_done", 32'(done), 32'd1);
        check("rstmid_we", 32'(we_cnt - we_snap), 32'd0);
        check("rstmid_mem", mem[16'h0260], 32'hcafe_0000);
        run(16'h0400, 16'h0260, 16'd14);
        check("rerun_lat", 32'(cyc), 32'd173);
        check_digest("rerun", 16'h0260, ref_sha(14), 8);

        load_msg(16'hfff8, 20, 101);
        run(16'hfff8, 16'h0240, 16'd20);
        check("wrap_lat", 32'(cyc), 32'd173);
        check_digest("wrap", 16'h0240, ref_sha(20), 8);

        load_msg(16'h0500, 70, 33);
        run(16'h0500, 16'h0250, 16'd70);
        check("clamp_lat", 32'(cyc), 32'd419);
        check_digest("clamp", 16'h0250, ref_sha(64), 8);

`ifdef SHA224_MODE_EN
        put(16'h0277, 32'hdead_beef);
        mode224 = 1'b1;
        run(16'h0100, 16'h0270, 16'd0);
        mode224 = 1'b0;
        check("n0_224_lat", 32'(cyc), 32'd90);
        check_digest("n0_224", 16'h0270, {224'hd14a028c2a3a2bc9476102bb288234c415a2b01f828ea62ac5b3e42f, 32'h0}, 7);
        check("n0_224_w7", mem[16'h0277], 32'hdead_beef);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/sha256_multiblock.md
Name: sha256_multiblock

Overview:
Next-generation SHA-256 hashing engine for the team's memory-mapped hash subsystem. It hashes a message of run-time length (0..MAX_WORDS 32-bit words) read from word-addressed memory. It generates FIPS 180-4 padding and the length field internally, and processes any number of 512-bit blocks. The 256-bit digest is written back to memory. It shares the memory-port protocol of the existing fixed-length engine, so it is a drop-in replacement in the top level.

Parameters:
MAX_WORDS, 64, largest accepted message length in words; sizes the word and block counters.
BLK_W, 8, width of the internal block counter; must satisfy 2**BLK_W > (MAX_WORDS+2)/16+1.

Ports:
clk  input  1  system clock; mem_clk is driven from it.
reset_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; sampled only in IDLE.
num_words  input  16  message length in words; sampled with start.
message_addr  input  16  word address of message word 0; sampled with start.
output_addr  input  16  word address for digest word H0; sampled with start.
done  output  1  high exactly while in IDLE.
mem_clk  output  1  equals clk.
mem_we  output  1  memory write enable.
mem_addr  output  16  memory word address.
mem_write_data  output  32  memory write data.
mem_read_data  input  32  read data, valid one cycle after its address is presented.

Behaviour:
- Reset values: done=1, mem_we=0, mem_addr=0, mem_write_data=0, state=IDLE. Reset asserted mid-operation aborts immediately; no further writes occur.
- FSM states: IDLE, READ, COMPUTE, UPDATE, WRITE.
- IDLE:
  - On start: latch inputs; clamp num_words to MAX_WORDS.
  - Load H0..H7 with the SHA-256 IVs.
  - Compute nblk = (N+2)/16 + 1 (integer division, N = latched length).
  - Set blk=0 and go to READ.
  - start is ignored outside IDLE.
- READ (17 cycles per block):
  - Cycles 0..15 present mem_addr = message_addr + blk*16 + t.
  - Data is captured on cycles 1..16 into W[t].
  - Global index g = blk*16+t selects the captured word:
    - g < N: mem_read_data.
    - g == N: 32'h80000000.
    - Last block, t==14: high 32 bits of (N*32); t==15: low 32 bits.
    - Otherwise: 0.
  - Padded words still issue a read address, but the data is discarded.
  - On entry, load a..h from H0..H7.
- COMPUTE (64 cycles, t=0..63):
  - One round per cycle using a rolling 16-entry schedule window.
  - For t≥16: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
  - All arithmetic is mod 2^32.
- UPDATE (1 cycle):
  - Hi += {a..h}.
  - If blk+1 < nblk: increment blk and go to READ.
  - Otherwise go to WRITE.
- WRITE (8 cycles):
  - mem_we=1, mem_addr = output_addr+k, mem_write_data = Hk, k=0..7.
  - Then mem_we=0 and go to IDLE.
- Latency from start to done: 82*nblk + 8 + 1 cycles. Example: N=0 or N=1 gives 91.
- Boundaries:
  - N=13 fits in 1 block; N=14 needs 2 blocks.
  - N=0 produces one padding-only block.
  - Address arithmetic wraps modulo 2^16.
  - start is held only for the first cycle; holding it high during done=1 after completion restarts the engine.

Optional Feature:
SHA224_MODE_EN:
- Defined: adds input port mode224 (1 bit, sampled with start). When mode224=1, the engine uses the SHA-224 IVs and WRITE emits 7 words (H0..H6), so latency is 1 cycle shorter.
- Undefined: the port is absent and behaviour is SHA-256 only.

Decomposition:
- Package sha256_pkg holds:
  - K[0:63] round constants and the IV arrays (SHA-256, plus SHA-224 when the macro is defined).
  - The state enum.
  - rightrotate, Sigma0/1, sigma0/1, ch, maj and the round function.
- Natural sub-module: sha256_msg_sched, the 16-word rolling window with load, shift and next-W generation.
- The top level keeps the FSM, padding and memory sequencing.

Test Plan:
- N=0 -> one block; digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 at output_addr..+7; done after 91 cycles.
- N=1, word 32'h61626364 ("abcd") -> digest 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589.
- N=13 vs N=14 random data -> 1 vs 2 blocks (latency 91 vs 173); digest matches the bench reference model.
- N=20 (existing engine's workload), message_addr=16'hFFF8 -> addresses wrap past 0; digest matches the reference model.
- reset_n pulsed low during COMPUTE of block 1 -> no mem_we afterwards; done=1; a new start yields a correct digest.
- SHA224_MODE_EN defined, mode224=1, N=0 -> d14a028c 2a3a2bc9 476102bb 288234c4 15a2b01f 828ea62a c5b3e42f written to 7 words; word 8 untouched.
